// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard, forwarding, flush and stall control for the 4-stage CPU,
//            with saturating stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_hazard_ctrl #(
   parameter int RA_W     = 3,
   parameter int FWD_EN   = 1,
   parameter int ZERO_REG = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dof_valid,
   input  logic [RA_W-1:0]  dof_aa,
   input  logic [RA_W-1:0]  dof_ba,
   input  logic             dof_ma,
   input  logic             dof_mb,
   input  logic             dof_rw,
   input  logic [RA_W-1:0]  dof_da,
   input  logic             dof_ld,
   input  logic             ex_br_taken,
   input  logic             clr_cnt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             ex_rw,
   output logic [RA_W-1:0]  ex_da,
   output logic             wb_rw,
   output logic [RA_W-1:0]  wb_da,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0]       c_sel_rf  = 2'b00;
   localparam logic [1:0]       c_sel_ex  = 2'b01;
   localparam logic [1:0]       c_sel_wb  = 2'b10;
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic             c_zero_en = (ZERO_REG != 0);

   logic             r_ex_rw;
   logic [RA_W-1:0]  r_ex_da;
   logic             r_ex_ld;
   logic             r_wb_rw;
   logic [RA_W-1:0]  r_wb_da;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_use_a;
   logic             w_use_b;
   logic             w_zero_a;
   logic             w_zero_b;
   logic             w_ex_a;
   logic             w_ex_b;
   logic             w_wb_a;
   logic             w_wb_b;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;
   logic             w_raw_stall;
   logic             w_stall_eff;

   assign w_use_a  = dof_valid & ~dof_ma;
   assign w_use_b  = dof_valid & ~dof_mb;
   assign w_zero_a = c_zero_en & (dof_aa == '0);
   assign w_zero_b = c_zero_en & (dof_ba == '0);

   assign w_ex_a = w_use_a & r_ex_rw & (r_ex_da == dof_aa) & ~w_zero_a;
   assign w_ex_b = w_use_b & r_ex_rw & (r_ex_da == dof_ba) & ~w_zero_b;
   assign w_wb_a = w_use_a & r_wb_rw & (r_wb_da == dof_aa) & ~w_zero_a;
   assign w_wb_b = w_use_b & r_wb_rw & (r_wb_da == dof_ba) & ~w_zero_b;

   generate
      if (FWD_EN != 0) begin : g_fwd
         // Only a load in EX cannot be bypassed: its data appears in WB.
         assign w_fwd_a     = w_ex_a ? c_sel_ex : (w_wb_a ? c_sel_wb : c_sel_rf);
         assign w_fwd_b     = w_ex_b ? c_sel_ex : (w_wb_b ? c_sel_wb : c_sel_rf);
         assign w_raw_stall = (w_ex_a | w_ex_b) & r_ex_ld;
      end else begin : g_stall_only
         assign w_fwd_a     = c_sel_rf;
         assign w_fwd_b     = c_sel_rf;
         assign w_raw_stall = w_ex_a | w_ex_b | w_wb_a | w_wb_b;
      end
   endgenerate

   assign w_stall_eff = w_raw_stall & ~ex_br_taken;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      fwd_a       = w_fwd_a;
      fwd_b       = w_fwd_b;
      if (rst) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
         fwd_a       = c_sel_rf;
         fwd_b       = c_sel_rf;
      end else if (ex_br_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (w_stall_eff) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   // The branching instruction itself still retires into WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_rw <= 1'b0;
         r_ex_da <= '0;
         r_ex_ld <= 1'b0;
         r_wb_rw <= 1'b0;
         r_wb_da <= '0;
      end else begin
         r_wb_rw <= r_ex_rw;
         r_wb_da <= r_ex_da;
         r_ex_rw <= dof_rw & dof_valid & ~idex_bubble;
         r_ex_da <= dof_da;
         r_ex_ld <= dof_ld;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (clr_cnt) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_eff && (r_stall_cnt != c_cnt_max))
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
         if (ex_br_taken && (r_flush_cnt != c_cnt_max))
            r_flush_cnt <= r_flush_cnt + c_cnt_one;
      end
   end

   assign ex_rw     = r_ex_rw;
   assign ex_da     = r_ex_da;
   assign wb_rw     = r_wb_rw;
   assign wb_da     = r_wb_da;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl variants.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       dof_valid, dof_ma, dof_mb, dof_rw, dof_ld;
   logic [2:0] dof_aa, dof_ba, dof_da;
   logic       ex_br_taken, clr_cnt;

   // Instance index: 0 default, 1 ZERO_REG=1, 2 FWD_EN=0, 3 CNT_W=4
   logic       pc_en_w[4], ifid_en_w[4], ifid_flush_w[4], idex_bubble_w[4];
   logic [1:0] fwd_a_w[4], fwd_b_w[4];
   logic       ex_rw_w[4], wb_rw_w[4];
   logic [2:0] ex_da_w[4], wb_da_w[4];
   logic [15:0] sc_w[3], fc_w[3];
   logic [3:0] sc4, fc4;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.RA_W(3), .FWD_EN(1), .ZERO_REG(0), .CNT_W(16)) u_fwd (
      .clk(clk), .rst(rst), .dof_valid(dof_valid), .dof_aa(dof_aa), .dof_ba(dof_ba),
      .dof_ma(dof_ma), .dof_mb(dof_mb), .dof_rw(dof_rw), .dof_da(dof_da), .dof_ld(dof_ld),
      .ex_br_taken(ex_br_taken), .clr_cnt(clr_cnt), .pc_en(pc_en_w[0]), .ifid_en(ifid_en_w[0]),
      .ifid_flush(ifid_flush_w[0]), .idex_bubble(idex_bubble_w[0]), .fwd_a(fwd_a_w[0]),
      .fwd_b(fwd_b_w[0]), .ex_rw(ex_rw_w[0]), .ex_da(ex_da_w[0]), .wb_rw(wb_rw_w[0]),
      .wb_da(wb_da_w[0]), .stall_cnt(sc_w[0]), .flush_cnt(fc_w[0]));

   pipe_hazard_ctrl #(.RA_W(3), .FWD_EN(1), .ZERO_REG(1), .CNT_W(16)) u_zr (
      .clk(clk), .rst(rst), .dof_valid(dof_valid), .dof_aa(dof_aa), .dof_ba(dof_ba),
      .dof_ma(dof_ma), .dof_mb(dof_mb), .dof_rw(dof_rw), .dof_da(dof_da), .dof_ld(dof_ld),
      .ex_br_taken(ex_br_taken), .clr_cnt(clr_cnt), .pc_en(pc_en_w[1]), .ifid_en(ifid_en_w[1]),
      .ifid_flush(ifid_flush_w[1]), .idex_bubble(idex_bubble_w[1]), .fwd_a(fwd_a_w[1]),
      .fwd_b(fwd_b_w[1]), .ex_rw(ex_rw_w[1]), .ex_da(ex_da_w[1]), .wb_rw(wb_rw_w[1]),
      .wb_da(wb_da_w[1]), .stall_cnt(sc_w[1]), .flush_cnt(fc_w[1]));

   pipe_hazard_ctrl #(.RA_W(3), .FWD_EN(0), .ZERO_REG(0), .CNT_W(16)) u_nf (
      .clk(clk), .rst(rst), .dof_valid(dof_valid), .dof_aa(dof_aa), .dof_ba(dof_ba),
      .dof_ma(dof_ma), .dof_mb(dof_mb), .dof_rw(dof_rw), .dof_da(dof_da), .dof_ld(dof_ld),
      .ex_br_taken(ex_br_taken), .clr_cnt(clr_cnt), .pc_en(pc_en_w[2]), .ifid_en(ifid_en_w[2]),
      .ifid_flush(ifid_flush_w[2]), .idex_bubble(idex_bubble_w[2]), .fwd_a(fwd_a_w[2]),
      .fwd_b(fwd_b_w[2]), .ex_rw(ex_rw_w[2]), .ex_da(ex_da_w[2]), .wb_rw(wb_rw_w[2]),
      .wb_da(wb_da_w[2]), .stall_cnt(sc_w[2]), .flush_cnt(fc_w[2]));

   pipe_hazard_ctrl #(.RA_W(3), .FWD_EN(1), .ZERO_REG(0), .CNT_W(4)) u_c4 (
      .clk(clk), .rst(rst), .dof_valid(dof_valid), .dof_aa(dof_aa), .dof_ba(dof_ba),
      .dof_ma(dof_ma), .dof_mb(dof_mb), .dof_rw(dof_rw), .dof_da(dof_da), .dof_ld(dof_ld),
      .ex_br_taken(ex_br_taken), .clr_cnt(clr_cnt), .pc_en(pc_en_w[3]), .ifid_en(ifid_en_w[3]),
      .ifid_flush(ifid_flush_w[3]), .idex_bubble(idex_bubble_w[3]), .fwd_a(fwd_a_w[3]),
      .fwd_b(fwd_b_w[3]), .ex_rw(ex_rw_w[3]), .ex_da(ex_da_w[3]), .wb_rw(wb_rw_w[3]),
      .wb_da(wb_da_w[3]), .stall_cnt(sc4), .flush_cnt(fc4));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      else
         n_pass++;
   endtask

   task automatic set_in(input logic v, input logic [2:0] aa, input logic [2:0] ba,
                         input logic ma, input logic mb, input logic rw,
                         input logic [2:0] da, input logic ld, input logic br);
      dof_valid = v;  dof_aa = aa; dof_ba = ba; dof_ma = ma; dof_mb = mb;
      dof_rw = rw;    dof_da = da; dof_ld = ld; ex_br_taken = br;
   endtask

   // Advance to the next negedge, then apply inputs and let logic settle.
   task automatic cyc(input logic v, input logic [2:0] aa, input logic [2:0] ba,
                      input logic ma, input logic mb, input logic rw,
                      input logic [2:0] da, input logic ld, input logic br);
      @(negedge clk);
      set_in(v, aa, ba, ma, mb, rw, da, ld, br);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clr_cnt = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_pc_en", pc_en_w[0], 0);
      chk("rst_ifid_en", ifid_en_w[0], 0);
      chk("rst_bubble", idex_bubble_w[0], 1);
      chk("rst_ex_rw", ex_rw_w[0], 0);
      chk("rst_stall_cnt", sc_w[0], 0);
      @(negedge clk);
      rst = 1'b0;

      // ALU result forwarding
      cyc(1, 1, 2, 0, 0, 1, 3, 0, 0);
      chk("alu_idle_pc_en", pc_en_w[0], 1);
      chk("alu_idle_fwd_a", fwd_a_w[0], 0);
      cyc(1, 3, 6, 0, 0, 0, 0, 0, 0);
      chk("alu_ex_da", ex_da_w[0], 3);
      chk("alu_fwd_a_ex", fwd_a_w[0], 2'b01);
      chk("alu_pc_en", pc_en_w[0], 1);
      cyc(1, 0, 3, 0, 0, 0, 0, 0, 0);
      chk("alu_wb_da", wb_da_w[0], 3);
      chk("alu_fwd_b_wb", fwd_b_w[0], 2'b10);
      dof_mb = 1'b1;
      #1;
      chk("alu_fwd_b_const", fwd_b_w[0], 2'b00);

      // Load-use: one stall, then forward from WB
      cyc(1, 0, 0, 0, 0, 1, 5, 1, 0);
      chk("ld_issue_pc_en", pc_en_w[0], 1);
      cyc(1, 1, 5, 0, 0, 0, 0, 0, 0);
      chk("ld_stall_pc_en", pc_en_w[0], 0);
      chk("ld_stall_ifid_en", ifid_en_w[0], 0);
      chk("ld_stall_bubble", idex_bubble_w[0], 1);
      chk("ld_stall_flush", ifid_flush_w[0], 0);
      cyc(1, 1, 5, 0, 0, 0, 0, 0, 0);
      chk("ld_after_pc_en", pc_en_w[0], 1);
      chk("ld_after_bubble", idex_bubble_w[0], 0);
      chk("ld_after_fwd_b", fwd_b_w[0], 2'b10);
      chk("ld_stall_cnt", sc_w[0], 1);

      // EX has priority over WB
      cyc(1, 0, 0, 0, 0, 1, 2, 0, 0);
      cyc(1, 7, 7, 0, 0, 1, 2, 0, 0);
      cyc(1, 2, 7, 0, 0, 0, 0, 0, 0);
      chk("prio_wb_rw", wb_rw_w[0], 1);
      chk("prio_fwd_a", fwd_a_w[0], 2'b01);

      // Branch taken during a load-use hazard
      cyc(1, 0, 0, 0, 0, 1, 5, 1, 0);
      cyc(1, 0, 5, 0, 0, 0, 0, 0, 1);
      chk("br_flush", ifid_flush_w[0], 1);
      chk("br_pc_en", pc_en_w[0], 1);
      chk("br_ifid_en", ifid_en_w[0], 1);
      chk("br_bubble", idex_bubble_w[0], 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("br_stall_cnt", sc_w[0], 1);
      chk("br_flush_cnt", fc_w[0], 1);
      chk("br_wb_rw", wb_rw_w[0], 1);
      chk("br_wb_da", wb_da_w[0], 5);

      // Asynchronous reset mid-stream
      cyc(1, 0, 0, 0, 0, 1, 4, 0, 0);
      cyc(1, 0, 0, 0, 0, 1, 6, 0, 0);
      chk("arst_pre_ex_rw", ex_rw_w[0], 1);
      rst = 1'b1;
      #1;
      chk("arst_ex_rw", ex_rw_w[0], 0);
      chk("arst_wb_rw", wb_rw_w[0], 0);
      chk("arst_stall_cnt", sc_w[0], 0);
      chk("arst_flush_cnt", fc_w[0], 0);
      chk("arst_pc_en", pc_en_w[0], 0);
      chk("arst_bubble", idex_bubble_w[0], 1);
      @(negedge clk);
      rst = 1'b0;

      // Register 0 as hardwired zero
      cyc(1, 0, 0, 0, 0, 1, 0, 1, 0);
      cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("zr_ex_rw", ex_rw_w[1], 1);
      chk("zr_ex_da", ex_da_w[1], 0);
      chk("zr_fwd_a", fwd_a_w[1], 2'b00);
      chk("zr_pc_en", pc_en_w[1], 1);
      chk("nozr_pc_en", pc_en_w[0], 0);

      // Stall-only mode: WB match stalls for one cycle
      do_reset();
      cyc(1, 0, 0, 0, 0, 1, 4, 0, 0);
      cyc(1, 1, 2, 0, 0, 0, 0, 0, 0);
      chk("nf_nomatch_pc_en", pc_en_w[2], 1);
      cyc(1, 4, 2, 0, 0, 0, 0, 0, 0);
      chk("nf_wb_pc_en", pc_en_w[2], 0);
      chk("nf_wb_bubble", idex_bubble_w[2], 1);
      chk("nf_fwd_a", fwd_a_w[2], 2'b00);
      cyc(1, 4, 2, 0, 0, 0, 0, 0, 0);
      chk("nf_after_pc_en", pc_en_w[2], 1);
      chk("nf_stall_cnt", sc_w[2], 1);

      // 4-bit counter saturation and clear; a repeated load-use pair stalls every other cycle
      do_reset();
      for (int i = 0; i < 40; i++) begin
         cyc(1, 0, 5, 0, 0, 1, 5, 1, 0);
         if (i == 10) chk("c4_mid_cnt", sc4, 5);
      end
      @(negedge clk);
      chk("c4_saturated", sc4, 15);
      chk("c4_flush_cnt", fc4, 0);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      #1;
      chk("c4_cleared", sc4, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
